// File: rtl/avalon_bus_arbiter.sv
// rtl/avalon_bus_arbiter.sv - Two-master round-robin arbiter onto a single shared slave port
// Master signals are passed through combinationally; only ownership and the last-granted pointer are stored.

module avalon_bus_arbiter #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,

    input  logic [ADDR_W-1:0] m0_address,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [31:0]       m0_writedata,
    input  logic [3:0]        m0_byteenable,
    output logic              m0_waitrequest,
    output logic [31:0]       m0_readdata,

    input  logic [ADDR_W-1:0] m1_address,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [31:0]       m1_writedata,
    input  logic [3:0]        m1_byteenable,
    output logic              m1_waitrequest,
    output logic [31:0]       m1_readdata,

    output logic [ADDR_W-1:0] s_address,
    output logic              s_read,
    output logic              s_write,
    output logic [31:0]       s_writedata,
    output logic [3:0]        s_byteenable,
    input  logic              s_waitrequest,
    input  logic [31:0]       s_readdata,

    output logic [1:0]        grant
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   last_grant, last_grant_nxt;
    logic   req0, req1;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    // last_grant resets to 1 so that m0 wins the first contention
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        s_address      = '0;
        s_read         = 1'b0;
        s_write        = 1'b0;
        s_writedata    = '0;
        s_byteenable   = '0;
        m0_waitrequest = req0;
        m1_waitrequest = req1;
        m0_readdata    = '0;
        m1_readdata    = '0;
        grant          = 2'b00;

        case (state)
            IDLE: begin
                if (req0 && (!req1 || last_grant))
                    state_nxt = BUSY0;
                else if (req1)
                    state_nxt = BUSY1;
            end

            BUSY0: begin
                grant          = 2'b01;
                s_address      = m0_address;
                s_writedata    = m0_writedata;
                s_byteenable   = m0_byteenable;
                s_write        = m0_write;
                s_read         = m0_read & ~m0_write;
                m0_waitrequest = s_waitrequest;
                m0_readdata    = s_readdata;
                // Dropping the request is an abort: leave without touching last_grant
                if (!req0) begin
                    state_nxt = IDLE;
                end else if (!s_waitrequest) begin
                    last_grant_nxt = 1'b0;
                    state_nxt      = req1 ? BUSY1 : IDLE;
                end
            end

            BUSY1: begin
                grant          = 2'b10;
                s_address      = m1_address;
                s_writedata    = m1_writedata;
                s_byteenable   = m1_byteenable;
                s_write        = m1_write;
                s_read         = m1_read & ~m1_write;
                m1_waitrequest = s_waitrequest;
                m1_readdata    = s_readdata;
                if (!req1) begin
                    state_nxt = IDLE;
                end else if (!s_waitrequest) begin
                    last_grant_nxt = 1'b1;
                    state_nxt      = req0 ? BUSY0 : IDLE;
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_avalon_bus_arbiter.sv
// tb/tb_avalon_bus_arbiter.sv - Directed and randomized checks of avalon_bus_arbiter against an ownership model

module tb_avalon_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] m0_address, m1_address, s_address;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_writedata, m1_writedata, s_writedata;
    logic [3:0]  m0_byteenable, m1_byteenable, s_byteenable;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata, m1_readdata, s_readdata;
    logic        s_read, s_write, s_waitrequest;
    logic [1:0]  grant;

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    // Model: who owns the slave (0 none, 1 m0, 2 m1) and which master was served last
    int m_owner;
    int m_last;

    always #5 clk = ~clk;

    avalon_bus_arbiter #(.ADDR_W(32)) dut (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .s_address(s_address), .s_read(s_read), .s_write(s_write),
        .s_writedata(s_writedata), .s_byteenable(s_byteenable),
        .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
        .grant(grant)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        logic        r0, r1;
        logic [31:0] e_addr, e_wd, e_rd0, e_rd1;
        logic [3:0]  e_be;
        logic        e_rd, e_wr, e_w0, e_w1;
        logic [1:0]  e_g;
        r0 = m0_read | m0_write;
        r1 = m1_read | m1_write;
        e_addr = 0; e_wd = 0; e_be = 0; e_rd = 0; e_wr = 0;
        e_w0 = r0; e_w1 = r1; e_rd0 = 0; e_rd1 = 0; e_g = 2'b00;
        if (m_owner == 1) begin
            e_g = 2'b01; e_addr = m0_address; e_wd = m0_writedata; e_be = m0_byteenable;
            e_wr = m0_write; e_rd = m0_read && !m0_write; e_w0 = s_waitrequest; e_rd0 = s_readdata;
        end else if (m_owner == 2) begin
            e_g = 2'b10; e_addr = m1_address; e_wd = m1_writedata; e_be = m1_byteenable;
            e_wr = m1_write; e_rd = m1_read && !m1_write; e_w1 = s_waitrequest; e_rd1 = s_readdata;
        end
        chk({tag, ".grant"}, 32'(grant), 32'(e_g));
        chk({tag, ".s_read"}, 32'(s_read), 32'(e_rd));
        chk({tag, ".s_write"}, 32'(s_write), 32'(e_wr));
        chk({tag, ".s_address"}, s_address, e_addr);
        chk({tag, ".s_writedata"}, s_writedata, e_wd);
        chk({tag, ".s_byteenable"}, 32'(s_byteenable), 32'(e_be));
        chk({tag, ".m0_wait"}, 32'(m0_waitrequest), 32'(e_w0));
        chk({tag, ".m1_wait"}, 32'(m1_waitrequest), 32'(e_w1));
        chk({tag, ".m0_readdata"}, m0_readdata, e_rd0);
        chk({tag, ".m1_readdata"}, m1_readdata, e_rd1);
    endtask

    task automatic predict(output int no, output int nl);
        bit r0, r1, mine, other;
        r0 = m0_read | m0_write;
        r1 = m1_read | m1_write;
        no = m_owner;
        nl = m_last;
        if (!reset) begin
            no = 0;
            nl = 1;
        end else if (m_owner == 0) begin
            if (r0 && r1) no = (m_last == 1) ? 1 : 2;
            else if (r0) no = 1;
            else if (r1) no = 2;
        end else begin
            mine  = (m_owner == 1) ? r0 : r1;
            other = (m_owner == 1) ? r1 : r0;
            if (!mine) no = 0;
            else if (!s_waitrequest) begin
                nl = m_owner - 1;
                no = other ? 3 - m_owner : 0;
            end
        end
    endtask

    task automatic cyc(input string tag);
        int no, nl;
        #1;
        check_model(tag);
        predict(no, nl);
        @(posedge clk);
        #1;
        m_owner = no;
        m_last  = nl;
    endtask

    initial begin
        reset = 1'b0;
        m0_address = 0; m0_read = 0; m0_write = 0; m0_writedata = 0; m0_byteenable = 0;
        m1_address = 0; m1_read = 0; m1_write = 0; m1_writedata = 0; m1_byteenable = 0;
        s_waitrequest = 0; s_readdata = 32'h5555_AAAA;
        m_owner = 0; m_last = 1;
        #2;
        chk("reset.grant", 32'(grant), 32'h0);
        chk("reset.s_read", 32'(s_read), 32'h0);
        chk("reset.m0_readdata", m0_readdata, 32'h0);
        cyc("reset");
        cyc("reset");
        reset = 1'b1;

        // Single read with one cycle of arbitration latency
        m0_read = 1; m0_address = 32'hBFC0_0000; s_readdata = 32'h8C02_0004;
        #1;
        chk("rd.c1_grant", 32'(grant), 32'h0);
        chk("rd.c1_m0_wait", 32'(m0_waitrequest), 32'h1);
        cyc("rd.c1");
        chk("rd.c2_grant", 32'(grant), 32'h1);
        chk("rd.c2_s_read", 32'(s_read), 32'h1);
        chk("rd.c2_s_address", s_address, 32'hBFC0_0000);
        chk("rd.c2_m0_readdata", m0_readdata, 32'h8C02_0004);
        chk("rd.c2_m0_wait", 32'(m0_waitrequest), 32'h0);
        cyc("rd.c2");
        m0_read = 0;
        cyc("rd.c3");

        // Contention straight after reset, then a stalled m1 write
        reset = 0; m_owner = 0; m_last = 1;
        cyc("rst2");
        reset = 1;
        m0_read = 1; m0_address = 32'h100;
        m1_write = 1; m1_address = 32'h10; m1_writedata = 32'hDEAD_BEEF; m1_byteenable = 4'hF;
        cyc("cont.idle");
        chk("cont.m0_first", 32'(grant), 32'h1);
        cyc("cont.m0");
        m0_read = 0;
        #1;
        chk("cont.m1_no_bubble", 32'(grant), 32'h2);
        chk("cont.s_write", 32'(s_write), 32'h1);
        chk("cont.s_writedata", s_writedata, 32'hDEAD_BEEF);
        s_waitrequest = 1; m0_read = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall.m1_wait", 32'(m1_waitrequest), 32'h1);
            chk("stall.grant", 32'(grant), 32'h2);
            chk("stall.s_address", s_address, 32'h10);
            chk("stall.m0_wait", 32'(m0_waitrequest), 32'h1);
            cyc("stall");
        end
        s_waitrequest = 0;
        cyc("stall.done");
        for (int i = 0; i < 6; i++) begin
            chk("fair.grant", 32'(grant), (i % 2 == 0) ? 32'h1 : 32'h2);
            cyc("fair");
        end
        m0_read = 0; m1_write = 0;
        cyc("fair.drop");

        // Reset during a stalled m0 read
        m0_read = 1; s_waitrequest = 1;
        cyc("rst_mid.idle");
        chk("rst_mid.grant_before", 32'(grant), 32'h1);
        chk("rst_mid.s_read_before", 32'(s_read), 32'h1);
        #1;
        reset = 0; m_owner = 0; m_last = 1;
        #1;
        chk("rst_mid.s_read", 32'(s_read), 32'h0);
        chk("rst_mid.grant", 32'(grant), 32'h0);
        chk("rst_mid.m0_readdata", m0_readdata, 32'h0);
        @(posedge clk);
        #1;
        reset = 1; m0_read = 0; m1_write = 1; m1_address = 32'h20; s_waitrequest = 0;
        cyc("rst_mid.rel");
        chk("rst_mid.m1_granted", 32'(grant), 32'h2);
        cyc("rst_mid.m1");
        m1_write = 0;
        cyc("rst_mid.idle2");

        // Abort by m1 must not disturb the pointer left by m0's completion
        m0_read = 1;
        cyc("abort.a");
        cyc("abort.b");
        m0_read = 0; m1_write = 1; s_waitrequest = 1;
        cyc("abort.c");
        chk("abort.m1_owner", 32'(grant), 32'h2);
        m1_write = 0;
        cyc("abort.drop");
        chk("abort.idle", 32'(grant), 32'h0);
        m0_read = 1; m1_write = 1; s_waitrequest = 0;
        cyc("abort.cont");
        chk("abort.keeps_last", 32'(grant), 32'h2);
        m0_read = 0; m1_write = 0;
        cyc("abort.end");

        // Randomized traffic, including occasional resets
        for (int i = 0; i < 400; i++) begin
            m0_read = ($urandom_range(0, 2) == 0);
            m0_write = ($urandom_range(0, 3) == 0);
            m1_read = ($urandom_range(0, 2) == 0);
            m1_write = ($urandom_range(0, 3) == 0);
            m0_address = $urandom; m1_address = $urandom;
            m0_writedata = $urandom; m1_writedata = $urandom;
            m0_byteenable = 4'($urandom); m1_byteenable = 4'($urandom);
            s_waitrequest = ($urandom_range(0, 2) == 0);
            s_readdata = $urandom;
            reset = ($urandom_range(0, 39) != 0);
            if (!reset) begin
                m_owner = 0;
                m_last = 1;
            end
            cyc("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/avalon_bus_arbiter.md
AVALON_BUS_ARBITER -- requirements
Module: avalon_bus_arbiter

Interface
REQ-001 Parameter: ADDR_W, default 32, address width of all master and slave ports.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 m0_address / m1_address  input  ADDR_W  master byte address (m0 = instruction port, m1 = data port).
REQ-005 m0_read, m0_write / m1_read, m1_write  input  1 each  master transfer strobes.
REQ-006 m0_writedata / m1_writedata  input  32  master write data.
REQ-007 m0_byteenable / m1_byteenable  input  4  master byte lanes.
REQ-008 m0_waitrequest / m1_waitrequest  output  1 each  stall to master.
REQ-009 m0_readdata / m1_readdata  output  32 each  read data to master.
REQ-010 s_address  output  ADDR_W; s_read, s_write  output  1; s_writedata  output  32; s_byteenable  output  4: shared slave port.
REQ-011 s_waitrequest  input  1; s_readdata  input  32: slave response, zero read latency (data valid when s_read=1 and s_waitrequest=0).
REQ-012 grant  output  2  one-hot current owner (bit0 = m0, bit1 = m1); 2'b00 when idle.

Function
REQ-013 The block SHALL implement states IDLE, BUSY0, BUSY1 plus a 1-bit last-granted pointer.
REQ-014 Master n request: req_n = mn_read | mn_write.
REQ-015 IDLE: slave strobes 0; s_address, s_writedata, s_byteenable 0; both master waitrequests = their req_n; grant = 00.
REQ-016 IDLE transition: only req0 -> BUSY0; only req1 -> BUSY1; both -> the master not equal to last-granted; none -> stay.
REQ-017 Arbitration latency SHALL be exactly one cycle: a request seen in IDLE is forwarded to the slave on the following cycle.
REQ-018 BUSYn: slave address/writedata/byteenable driven combinationally from master n; s_write = mn_write; s_read = mn_read & ~mn_write (write wins if both asserted).
REQ-019 BUSYn: mn_waitrequest = s_waitrequest; the other master's waitrequest = its req.
REQ-020 The granted master SHALL receive s_readdata; the non-granted master's readdata SHALL be 0.
REQ-021 Completion: in BUSYn, a cycle with req_n=1 and s_waitrequest=0; on that edge last-granted <= n.
REQ-022 On completion: other master requesting -> BUSY(other) with no idle bubble; else -> IDLE.
REQ-023 A granted master dropping req_n while s_waitrequest=1 (abort) SHALL return to IDLE next cycle without updating last-granted.
REQ-024 Back-to-back requests by the same master SHALL pass through IDLE (one bubble) when the other master is idle.
REQ-025 No master SHALL wait more than one full transfer of the other master once requesting (round-robin fairness).
REQ-026 Masters hold address/data/strobes stable while waitrequest=1; the arbiter SHALL NOT register master data (pass-through only).

Reset
REQ-027 reset=0 SHALL immediately force IDLE, grant=00, all slave outputs 0, master readdata 0, last-granted=1 (m0 wins the first contention).
REQ-028 Reset asserted mid-transfer SHALL drop s_read/s_write in the same cycle; the transfer is abandoned, no replay after release.
REQ-029 First arbitration SHALL occur on the first rising edge after reset returns to 1.

Verification
REQ-030 Single read: m0_read=1, addr 0xBFC00000, s_waitrequest=0, s_readdata=0x8C020004 -> cycle1 grant=00, m0_waitrequest=1; cycle2 grant=01, s_read=1, s_address=0xBFC00000, m0_readdata=0x8C020004, m0_waitrequest=0.
REQ-031 Contention after reset: m0_read and m1_write (addr 0x10, data 0xDEADBEEF, be 4'hF) same cycle -> m0 served first; m1 forwarded on the cycle after m0 completes with no IDLE bubble; s_writedata=0xDEADBEEF.
REQ-032 Slave stall: s_waitrequest=1 for 3 cycles in BUSY1 -> m1_waitrequest=1 those 3 cycles, s_* outputs stable, grant stays 10, m0 held off throughout.
REQ-033 Fairness: both masters request continuously for 6 transfers -> grant alternates 01,10,01,10,01,10.
REQ-034 Reset mid-stall: reset=0 during BUSY0 with s_waitrequest=1 -> s_read=0 and grant=00 in the same cycle; after release, m1 request alone granted after one cycle.
REQ-035 Abort: m1 drops m1_write while stalled -> IDLE next cycle, last-granted unchanged (verified by next contention ordering).
